// File: rtl/inst_seq_accel.sv
// rtl/inst_seq_accel.sv - programmable instruction-pair pattern matcher with replacement injection
module inst_seq_accel #(
    parameter int INST_W    = 16,
    parameter int PC_W      = 10,
    parameter int NUM_PAT   = 2,
    parameter int PAT_PAIRS = 10,
    parameter int INJ_PAIRS = 2,
    localparam int PAT_W     = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    localparam int MAX_PAIRS = (PAT_PAIRS > INJ_PAIRS) ? PAT_PAIRS : INJ_PAIRS,
    localparam int IDX_W     = $clog2(MAX_PAIRS),
    localparam int PAIR_W    = 2 * INST_W
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              cfg_we,
    input  logic              cfg_tbl,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [PAIR_W-1:0] cfg_data,
    input  logic [NUM_PAT-1:0] cfg_en,
    input  logic              in_valid,
    input  logic              flush,
    input  logic [INST_W-1:0] inst0,
    input  logic [INST_W-1:0] inst1,
    input  logic [PC_W-1:0]   pc_dec,
    output logic              inj_active,
    output logic [INST_W-1:0] inj_inst0,
    output logic [INST_W-1:0] inj_inst1,
    output logic              pc_hold,
    output logic [PC_W-1:0]   resume_pc,
    output logic [PAT_W-1:0]  hit_pat,
    output logic [15:0]       hit_cnt
);

    localparam int CNT_W = $clog2(PAT_PAIRS);
    localparam int PTR_W = (INJ_PAIRS > 1) ? $clog2(INJ_PAIRS) : 1;

    typedef enum logic {IDLE = 1'b0, INJECT = 1'b1} stateT;

    stateT             state;
    logic [PAIR_W-1:0] patTbl [NUM_PAT][PAT_PAIRS];
    logic [PAIR_W-1:0] injTbl [NUM_PAT][INJ_PAIRS];
    logic [PAIR_W-1:0] injBuf [INJ_PAIRS];
    logic [CNT_W-1:0]  cnt [NUM_PAT];
    logic [PTR_W-1:0]  injPtr;
    logic [PTR_W-1:0]  ptrNext;
    logic              injActive;
    logic [PAIR_W-1:0] outPair;
    logic [PC_W-1:0]   resumePc;
    logic [PAT_W-1:0]  hitPat;
    logic [15:0]       hitCnt;

    logic [PAIR_W-1:0] pair;
    logic [PAIR_W-1:0] curEntry [NUM_PAT];
    logic [NUM_PAT-1:0] matchCur;
    logic [NUM_PAT-1:0] matchFirst;
    logic [NUM_PAT-1:0] lastHit;
    logic              anyHit;
    logic [PAT_W-1:0]  hitIdx;
    logic [PAIR_W-1:0] hitRow [INJ_PAIRS];

    assign ptrNext    = injPtr + PTR_W'(1);
    assign inj_active = injActive;
    assign pc_hold    = injActive;
    assign {inj_inst1, inj_inst0} = outPair;
    assign resume_pc  = resumePc;
    assign hit_pat    = hitPat;
    assign hit_cnt    = hitCnt;

    // Compare the decode pair against each pattern's expected entry and its first entry
    always_comb begin
        pair = {inst1, inst0};
        for (int p = 0; p < NUM_PAT; p++) begin
            curEntry[p] = patTbl[p][0];
            for (int k = 1; k < PAT_PAIRS; k++) begin
                if (cnt[p] == CNT_W'(k)) curEntry[p] = patTbl[p][k];
            end
            matchCur[p]   = (pair == curEntry[p]);
            matchFirst[p] = (pair == patTbl[p][0]);
            lastHit[p]    = (state == IDLE) && in_valid && !flush && cfg_en[p] &&
                            (cnt[p] == CNT_W'(PAT_PAIRS - 1)) && matchCur[p];
        end
    end

    // Lowest-numbered hitting pattern wins; select its replacement row
    always_comb begin
        anyHit = |lastHit;
        hitIdx = '0;
        for (int p = NUM_PAT - 1; p >= 0; p--) begin
            if (lastHit[p]) hitIdx = PAT_W'(p);
        end
        for (int k = 0; k < INJ_PAIRS; k++) begin
            hitRow[k] = injTbl[0][k];
            for (int p = 1; p < NUM_PAT; p++) begin
                if (hitIdx == PAT_W'(p)) hitRow[k] = injTbl[p][k];
            end
        end
    end

    // Table writes; out-of-range indices match no entry and are dropped
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int p = 0; p < NUM_PAT; p++) begin
                for (int k = 0; k < PAT_PAIRS; k++) patTbl[p][k] <= '0;
                for (int k = 0; k < INJ_PAIRS; k++) injTbl[p][k] <= '0;
            end
        end else if (cfg_we) begin
            for (int p = 0; p < NUM_PAT; p++) begin
                for (int k = 0; k < PAT_PAIRS; k++) begin
                    if (!cfg_tbl && cfg_pat == PAT_W'(p) && cfg_idx == IDX_W'(k))
                        patTbl[p][k] <= cfg_data;
                end
                for (int k = 0; k < INJ_PAIRS; k++) begin
                    if (cfg_tbl && cfg_pat == PAT_W'(p) && cfg_idx == IDX_W'(k))
                        injTbl[p][k] <= cfg_data;
                end
            end
        end
    end

    // Match/inject FSM; the replacement row is snapshotted at the hit so later writes cannot disturb it
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            injActive <= 1'b0;
            injPtr    <= '0;
            outPair   <= '0;
            resumePc  <= '0;
            hitPat    <= '0;
            hitCnt    <= '0;
            for (int k = 0; k < INJ_PAIRS; k++) injBuf[k] <= '0;
            for (int p = 0; p < NUM_PAT; p++) cnt[p] <= '0;
        end else if (state == IDLE) begin
            if (anyHit) begin
                state     <= INJECT;
                injActive <= 1'b1;
                injPtr    <= '0;
                outPair   <= hitRow[0];
                resumePc  <= pc_dec + PC_W'(2);
                hitPat    <= hitIdx;
                if (hitCnt != 16'hFFFF) hitCnt <= hitCnt + 16'd1;
                for (int k = 0; k < INJ_PAIRS; k++) injBuf[k] <= hitRow[k];
                for (int p = 0; p < NUM_PAT; p++) cnt[p] <= '0;
            end else begin
                for (int p = 0; p < NUM_PAT; p++) begin
                    if (flush || !cfg_en[p] || cfg_we)
                        cnt[p] <= '0;
                    else if (in_valid)
                        cnt[p] <= matchCur[p] ? cnt[p] + CNT_W'(1)
                                              : (matchFirst[p] ? CNT_W'(1) : {CNT_W{1'b0}});
                end
            end
        end else begin
            for (int p = 0; p < NUM_PAT; p++) cnt[p] <= '0;
            if (injPtr == PTR_W'(INJ_PAIRS - 1)) begin
                state     <= IDLE;
                injActive <= 1'b0;
                injPtr    <= '0;
                outPair   <= '0;
            end else begin
                injPtr <= ptrNext;
                for (int k = 0; k < INJ_PAIRS; k++) begin
                    if (ptrNext == PTR_W'(k)) outPair <= injBuf[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_seq_accel.sv
// tb/tb_inst_seq_accel.sv - self-checking bench for inst_seq_accel
module tb_inst_seq_accel;

    localparam logic [31:0] PA = 32'h0A01_0A00;
    localparam logic [31:0] PB = 32'h0B01_0B00;
    localparam logic [31:0] PC = 32'h0C01_0C00;
    localparam logic [31:0] PX = 32'h0F01_0F00;
    localparam logic [31:0] I0 = 32'h1001_1000;
    localparam logic [31:0] I1 = 32'h2001_2000;
    localparam logic [31:0] J0 = 32'h3001_3000;
    localparam logic [31:0] J1 = 32'h4001_4000;

    logic        clk = 1'b0;
    logic        resetN;
    logic        cfg_we;
    logic        cfg_tbl;
    logic [0:0]  cfg_pat;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_data;
    logic [1:0]  cfg_en;
    logic        in_valid;
    logic        flush;
    logic [15:0] inst0, inst1;
    logic [9:0]  pc_dec;
    logic        inj_active;
    logic [15:0] inj_inst0, inj_inst1;
    logic        pc_hold;
    logic [9:0]  resume_pc;
    logic [0:0]  hit_pat;
    logic [15:0] hit_cnt;

    int checks = 0;
    int errors = 0;

    inst_seq_accel #(
        .INST_W(16), .PC_W(10), .NUM_PAT(2), .PAT_PAIRS(3), .INJ_PAIRS(2)
    ) dut (
        .clk(clk), .resetN(resetN), .cfg_we(cfg_we), .cfg_tbl(cfg_tbl), .cfg_pat(cfg_pat),
        .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_en(cfg_en), .in_valid(in_valid),
        .flush(flush), .inst0(inst0), .inst1(inst1), .pc_dec(pc_dec),
        .inj_active(inj_active), .inj_inst0(inj_inst0), .inj_inst1(inj_inst1),
        .pc_hold(pc_hold), .resume_pc(resume_pc), .hit_pat(hit_pat), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        fl;
        logic [31:0] pr;
        int          pc;
        logic        act;
        logic [31:0] inj;
        int          res;
        logic        hp;
        int          hc;
    } vecT;

    vecT vecs[$];

    function automatic vecT mk(input logic v, input logic fl, input logic [31:0] pr, input int pc,
                               input logic act, input logic [31:0] inj, input int res,
                               input logic hp, input int hc);
        vecT r;
        r.v = v; r.fl = fl; r.pr = pr; r.pc = pc;
        r.act = act; r.inj = inj; r.res = res; r.hp = hp; r.hc = hc;
        return r;
    endfunction

    function automatic logic [63:0] obs();
        return {3'b0, inj_active, pc_hold, inj_inst1, inj_inst0, resume_pc, hit_pat, hit_cnt};
    endfunction

    function automatic logic [63:0] expv(input logic act, input logic [31:0] inj, input int res,
                                         input logic hp, input int hc);
        return {3'b0, act, act, inj, 10'(res), hp, 16'(hc)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (act,hold,inj1,inj0,res,hp,hc)", nm, act, exp);
        end
    endtask

    task automatic writeCfg(input logic tbl, input logic pat, input logic [1:0] idx, input logic [31:0] d);
        in_valid = 1'b0; flush = 1'b0;
        cfg_we = 1'b1; cfg_tbl = tbl; cfg_pat = pat; cfg_idx = idx; cfg_data = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic hs(input string nm, input logic v, input logic [31:0] pr, input int pc,
                      input logic act, input logic [31:0] inj, input int res, input logic hp, input int hc);
        in_valid = v; flush = 1'b0; {inst1, inst0} = pr; pc_dec = 10'(pc);
        @(posedge clk); #1;
        chk(nm, obs(), expv(act, inj, res, hp, hc));
    endtask

    // Behavioural reference: per-pattern matched-prefix length plus a queue of pairs still to inject
    int          mCnt [2];
    logic [31:0] mPat [2][3];
    logic [31:0] mInj [2][2];
    logic [31:0] mQ [$];
    int          mRes, mHp, mHc;

    task automatic rtick(input string nm);
        int hitP;
        logic [31:0] pr;
        logic act;
        logic [31:0] inj;
        pr = {inst1, inst0};
        if (mQ.size() > 0) begin
            void'(mQ.pop_front());
            mCnt[0] = 0; mCnt[1] = 0;
        end else begin
            hitP = -1;
            for (int p = 0; p < 2; p++)
                if (hitP < 0 && cfg_en[p] && in_valid && !flush && mCnt[p] == 2 && pr == mPat[p][2])
                    hitP = p;
            if (hitP >= 0) begin
                for (int k = 0; k < 2; k++) mQ.push_back(mInj[hitP][k]);
                mRes = (int'(pc_dec) + 2) % 1024;
                mHp = hitP;
                if (mHc < 65535) mHc++;
                mCnt[0] = 0; mCnt[1] = 0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (flush || !cfg_en[p]) mCnt[p] = 0;
                    else if (in_valid) begin
                        if (pr == mPat[p][mCnt[p]]) mCnt[p]++;
                        else mCnt[p] = (pr == mPat[p][0]) ? 1 : 0;
                    end
                end
            end
        end
        if (cfg_we) begin
            mCnt[0] = 0; mCnt[1] = 0;
            if (!cfg_tbl && int'(cfg_idx) < 3) mPat[cfg_pat][cfg_idx] = cfg_data;
            if (cfg_tbl && int'(cfg_idx) < 2) mInj[cfg_pat][cfg_idx[0]] = cfg_data;
        end
        @(posedge clk); #1;
        act = (mQ.size() > 0);
        inj = act ? mQ[0] : 32'h0;
        chk(nm, obs(), expv(act, inj, mRes, mHp[0], mHc));
    endtask

    logic [31:0] alpha [4];

    initial begin
        alpha[0] = PA; alpha[1] = PB; alpha[2] = PC; alpha[3] = PX;
        resetN = 1'b0; cfg_we = 1'b0; cfg_tbl = 1'b0; cfg_pat = 1'b0; cfg_idx = 2'd0;
        cfg_data = 32'h0; cfg_en = 2'b11; in_valid = 1'b0; flush = 1'b0;
        inst0 = 16'h0; inst1 = 16'h0; pc_dec = 10'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", obs(), expv(0, 0, 0, 0, 0));
        resetN = 1'b1;

        writeCfg(0, 0, 0, PA); writeCfg(0, 0, 1, PB); writeCfg(0, 0, 2, PC);
        writeCfg(1, 0, 0, I0); writeCfg(1, 0, 1, I1);
        writeCfg(0, 1, 0, 32'h5555_5555); writeCfg(0, 1, 1, 32'h6666_6666);
        writeCfg(0, 1, 2, 32'h7777_7777);
        writeCfg(1, 1, 0, J0); writeCfg(1, 1, 1, J1);

        // Directed per-cycle vectors: basic hit, broken run, overlap restart, flush, bubble
        vecs.push_back(mk(1, 0, PA, 100, 0, 0,   0, 0, 0));
        vecs.push_back(mk(1, 0, PB, 102, 0, 0,   0, 0, 0));
        vecs.push_back(mk(1, 0, PC, 104, 1, I0, 106, 0, 1));
        vecs.push_back(mk(0, 0, 0,    0, 1, I1, 106, 0, 1));
        vecs.push_back(mk(0, 0, 0,    0, 0, 0, 106, 0, 1));
        vecs.push_back(mk(1, 0, PA, 200, 0, 0, 106, 0, 1));
        vecs.push_back(mk(1, 0, PB, 202, 0, 0, 106, 0, 1));
        vecs.push_back(mk(1, 0, PX, 204, 0, 0, 106, 0, 1));
        vecs.push_back(mk(1, 0, PA, 206, 0, 0, 106, 0, 1));
        vecs.push_back(mk(1, 0, PB, 208, 0, 0, 106, 0, 1));
        vecs.push_back(mk(1, 0, PC, 210, 1, I0, 212, 0, 2));
        vecs.push_back(mk(0, 0, 0,    0, 1, I1, 212, 0, 2));
        vecs.push_back(mk(0, 0, 0,    0, 0, 0, 212, 0, 2));
        vecs.push_back(mk(1, 0, PA, 300, 0, 0, 212, 0, 2));
        vecs.push_back(mk(1, 0, PA, 302, 0, 0, 212, 0, 2));
        vecs.push_back(mk(1, 0, PB, 304, 0, 0, 212, 0, 2));
        vecs.push_back(mk(1, 0, PC, 306, 1, I0, 308, 0, 3));
        vecs.push_back(mk(0, 0, 0,    0, 1, I1, 308, 0, 3));
        vecs.push_back(mk(0, 0, 0,    0, 0, 0, 308, 0, 3));
        vecs.push_back(mk(1, 0, PA, 400, 0, 0, 308, 0, 3));
        vecs.push_back(mk(1, 0, PB, 402, 0, 0, 308, 0, 3));
        vecs.push_back(mk(0, 1, 0,    0, 0, 0, 308, 0, 3));
        vecs.push_back(mk(1, 0, PC, 404, 0, 0, 308, 0, 3));
        vecs.push_back(mk(1, 0, PA, 500, 0, 0, 308, 0, 3));
        vecs.push_back(mk(0, 0, PX, 501, 0, 0, 308, 0, 3));
        vecs.push_back(mk(1, 0, PB, 502, 0, 0, 308, 0, 3));
        vecs.push_back(mk(1, 0, PC, 504, 1, I0, 506, 0, 4));
        vecs.push_back(mk(1, 1, PA,   0, 1, I1, 506, 0, 4));
        vecs.push_back(mk(1, 0, PB,   0, 0, 0, 506, 0, 4));
        vecs.push_back(mk(1, 0, PC,   0, 0, 0, 506, 0, 4));

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].v; flush = vecs[i].fl;
            {inst1, inst0} = vecs[i].pr; pc_dec = 10'(vecs[i].pc);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), obs(),
                expv(vecs[i].act, vecs[i].inj, vecs[i].res, vecs[i].hp, vecs[i].hc));
        end
        flush = 1'b0;

        // Identical patterns: lowest index wins, then disabling it lets pattern 1 hit
        writeCfg(0, 1, 0, PA); writeCfg(0, 1, 1, PB); writeCfg(0, 1, 2, PC);
        hs("prio_a", 1, PA, 600, 0, 0, 506, 0, 4);
        hs("prio_b", 1, PB, 602, 0, 0, 506, 0, 4);
        hs("prio_hit", 1, PC, 604, 1, I0, 606, 0, 5);
        hs("prio_i1", 0, 0, 0, 1, I1, 606, 0, 5);
        hs("prio_end", 0, 0, 0, 0, 0, 606, 0, 5);
        cfg_en = 2'b10;
        hs("dis_a", 1, PA, 700, 0, 0, 606, 0, 5);
        hs("dis_b", 1, PB, 702, 0, 0, 606, 0, 5);
        hs("dis_hit", 1, PC, 704, 1, J0, 706, 1, 6);
        hs("dis_j1", 0, 0, 0, 1, J1, 706, 1, 6);
        hs("dis_end", 0, 0, 0, 0, 0, 706, 1, 6);
        cfg_en = 2'b01;

        // PC wrap, and a table write during injection leaving the current replacement intact
        hs("wrap_a", 1, PA, 1018, 0, 0, 706, 1, 6);
        hs("wrap_b", 1, PB, 1020, 0, 0, 706, 1, 6);
        hs("wrap_hit", 1, PC, 1022, 1, I0, 0, 0, 7);
        writeCfg(1, 0, 1, 32'hDEAD_BEEF);
        chk("inj_wr_kept", obs(), expv(1, I1, 0, 0, 7));
        hs("wrap_end", 0, 0, 0, 0, 0, 0, 0, 7);
        writeCfg(1, 0, 1, I1);

        // Saturating hit counter
        force dut.hitCnt = 16'hFFFF;
        #1 release dut.hitCnt;
        hs("sat_a", 1, PA, 10, 0, 0, 0, 0, 65535);
        hs("sat_b", 1, PB, 12, 0, 0, 0, 0, 65535);
        hs("sat_hit", 1, PC, 14, 1, I0, 16, 0, 65535);
        hs("sat_i1", 0, 0, 0, 1, I1, 16, 0, 65535);
        hs("sat_end", 0, 0, 0, 0, 0, 16, 0, 65535);

        // Asynchronous reset in the second injection cycle, then cleared tables never match
        cfg_en = 2'b11;
        hs("rst_a", 1, PA, 20, 0, 0, 16, 0, 65535);
        hs("rst_b", 1, PB, 22, 0, 0, 16, 0, 65535);
        hs("rst_hit", 1, PC, 24, 1, I0, 26, 0, 65535);
        hs("rst_i1", 0, 0, 0, 1, I1, 26, 0, 65535);
        #2 resetN = 1'b0;
        #1 chk("rst_abort", obs(), expv(0, 0, 0, 0, 0));
        @(posedge clk); #1;
        resetN = 1'b1;
        hs("post_a", 1, PA, 30, 0, 0, 0, 0, 0);
        hs("post_b", 1, PB, 32, 0, 0, 0, 0, 0);
        hs("post_c", 1, PC, 34, 0, 0, 0, 0, 0);
        hs("post_d", 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomised run against the reference model, starting from the reset state
        for (int p = 0; p < 2; p++) begin
            mCnt[p] = 0;
            for (int k = 0; k < 3; k++) mPat[p][k] = 32'h0;
            for (int k = 0; k < 2; k++) mInj[p][k] = 32'h0;
        end
        mQ.delete(); mRes = 0; mHp = 0; mHc = 0;
        in_valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cfg_we = 1'b1; cfg_tbl = 1'b0; cfg_pat = 1'b0; cfg_idx = 2'(k); cfg_data = alpha[k];
            rtick("rprog0");
            cfg_pat = 1'b1; cfg_data = alpha[(k + 1) % 3];
            rtick("rprog1");
        end
        for (int k = 0; k < 2; k++) begin
            cfg_we = 1'b1; cfg_tbl = 1'b1; cfg_pat = 1'b0; cfg_idx = 2'(k); cfg_data = k ? I1 : I0;
            rtick("rinj0");
            cfg_pat = 1'b1; cfg_data = k ? J1 : J0;
            rtick("rinj1");
        end
        for (int i = 0; i < 2000; i++) begin
            in_valid = ($urandom_range(0, 99) < 85);
            flush    = ($urandom_range(0, 99) < 4);
            {inst1, inst0} = alpha[$urandom_range(0, 3)];
            pc_dec   = 10'($urandom);
            cfg_en   = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b11;
            cfg_we   = ($urandom_range(0, 99) < 3);
            cfg_tbl  = 1'($urandom);
            cfg_pat  = 1'($urandom);
            cfg_idx  = 2'($urandom);
            cfg_data = alpha[$urandom_range(0, 3)];
            rtick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
